// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcodes,
// ALU field encodings and the bundle of datapath control signals.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_IR_LOAD  = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_LW_WB    = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore output map: every datapath control is a pure function of the state.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_IR_LOAD: ctrl.ir_write = 1'b1;
      // Branch target is precomputed into the ALU register during decode
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_LW_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_I_WB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_HALT: ctrl.halted     = 1'b1;
      S_TRAP: ctrl.illegal_op = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath sequencer: state register, next-state logic and
// retired-instruction counter; outputs come from ctrl_out_decode.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opCode,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                halted,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_dbg
);

  state_e              state;
  state_e              state_next;
  logic                is_store;
  logic                retire;
  logic [RETIRE_W-1:0] retired_cnt;
  ctrl_t               ctrl_dec;
  ctrl_t               ctrl;

  ctrl_out_decode u_out_decode (
    .state (state),
    .ctrl  (ctrl_dec)
  );

  // Load/store choice is latched in DECODE so opCode is only read there
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   state_next = S_IR_LOAD;
      S_IR_LOAD: state_next = S_DECODE;
      S_DECODE: begin
        case (opCode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_ADDI:      state_next = S_I_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_HALT:      state_next = S_HALT;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_next = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_next = S_LW_WB;
      S_R_EXEC:   state_next = S_R_WB;
      S_I_EXEC:   state_next = S_I_WB;
      S_LW_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  assign retire = state inside {S_LW_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      is_store    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) is_store <= (opCode == OP_SW);
      if (retire) retired_cnt <= retired_cnt + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset kills every enable combinationally, including FETCH's
  assign ctrl = reset ? '0 : ctrl_dec;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign halted      = ctrl.halted;
  assign illegal_op  = ctrl.illegal_op;
  assign retired     = retired_cnt;
  assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle control vectors
// are predicted from per-instruction phase lists and an instruction count.
module tb_multicycle_controller;

  localparam int P_FETCH = 0, P_IR = 1, P_DEC = 2, P_MADDR = 3, P_MRD = 4,
                 P_LWWB = 5, P_MWR = 6, P_REX = 7, P_RWB = 8, P_IEX = 9,
                 P_IWB = 10, P_BR = 11, P_JMP = 12, P_HALT = 13, P_TRAP = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opCode = 6'd0;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic ALUSrcA, RegWrite, RegDst, halted, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [31:0] retired;
  logic [3:0] state_dbg;

  logic s_PCWrite, s_PCWriteCond, s_IorD, s_MemRead, s_MemWrite, s_MemtoReg, s_IRWrite;
  logic s_ALUSrcA, s_RegWrite, s_RegDst, s_halted, s_illegal_op;
  logic [1:0] s_PCSource, s_ALUSrcB, s_ALUOp;
  logic [2:0] s_retired;
  logic [3:0] s_state_dbg;

  logic [17:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, halted, illegal_op};

  int errors = 0;
  int checks = 0;
  logic [31:0] model_ret = 32'd0;

  always #5 clk = ~clk;

  multicycle_controller #(.RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .opCode(opCode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .halted(halted), .illegal_op(illegal_op), .retired(retired),
    .state_dbg(state_dbg)
  );

  // Narrow counter instance exposes the all-ones to zero wrap quickly
  multicycle_controller #(.RETIRE_W(3)) dut_small (
    .clk(clk), .reset(reset), .opCode(opCode),
    .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .IorD(s_IorD), .MemRead(s_MemRead),
    .MemWrite(s_MemWrite), .MemtoReg(s_MemtoReg), .IRWrite(s_IRWrite), .ALUSrcA(s_ALUSrcA),
    .RegWrite(s_RegWrite), .RegDst(s_RegDst), .PCSource(s_PCSource), .ALUSrcB(s_ALUSrcB),
    .ALUOp(s_ALUOp), .halted(s_halted), .illegal_op(s_illegal_op), .retired(s_retired),
    .state_dbg(s_state_dbg)
  );

  function automatic logic [17:0] phase_ctrl(input int ph);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, hl, il;
    logic [1:0] pcsrc, srcb, aluop;
    {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, hl, il} = '0;
    {pcsrc, srcb, aluop} = '0;
    case (ph)
      P_FETCH: begin pcw = 1; mr = 1; srcb = 2'b01; end
      P_IR:    irw = 1;
      P_DEC:   srcb = 2'b11;
      P_MADDR: begin srca = 1; srcb = 2'b10; end
      P_MRD:   begin iord = 1; mr = 1; srca = 1; srcb = 2'b10; end
      P_LWWB:  begin m2r = 1; rw = 1; end
      P_MWR:   begin iord = 1; mw = 1; srca = 1; srcb = 2'b10; end
      P_REX:   begin srca = 1; aluop = 2'b10; end
      P_RWB:   begin rd = 1; rw = 1; end
      P_IEX:   begin srca = 1; srcb = 2'b10; end
      P_IWB:   rw = 1;
      P_BR:    begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      P_JMP:   begin pcw = 1; pcsrc = 2'b10; end
      P_HALT:  hl = 1;
      P_TRAP:  il = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, pcsrc, srcb, aluop, hl, il};
  endfunction

  function automatic logic [5:0] rand_legal();
    logic [5:0] ops [6];
    ops[0] = 6'b000000; ops[1] = 6'b000010; ops[2] = 6'b000100;
    ops[3] = 6'b001000; ops[4] = 6'b100011; ops[5] = 6'b101011;
    return ops[$urandom_range(0, 5)];
  endfunction

  // Runs one instruction from FETCH, checking every cycle; for HALT or an
  // illegal opcode it stops after DECODE and leaves the caller in the trap.
  task automatic run_instr(input logic [5:0] op);
    int ph[6];
    int n;
    bit retires;
    ph[0] = P_FETCH; ph[1] = P_IR; ph[2] = P_DEC;
    n = 3; retires = 1'b1;
    case (op)
      6'b000000: begin ph[3] = P_REX; ph[4] = P_RWB; n = 5; end
      6'b000010: begin ph[3] = P_JMP; n = 4; end
      6'b000100: begin ph[3] = P_BR; n = 4; end
      6'b001000: begin ph[3] = P_IEX; ph[4] = P_IWB; n = 5; end
      6'b100011: begin ph[3] = P_MADDR; ph[4] = P_MRD; ph[5] = P_LWWB; n = 6; end
      6'b101011: begin ph[3] = P_MADDR; ph[4] = P_MWR; n = 5; end
      default:   retires = 1'b0;
    endcase
    opCode = op;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ctrl !== phase_ctrl(ph[i])) begin
        errors++;
        $display("FAIL ctrl op=%b step=%0d got=%b want=%b", op, i, ctrl, phase_ctrl(ph[i]));
      end
      checks++;
      if ((state_dbg === 4'd0) !== (ph[i] == P_FETCH)) begin
        errors++;
        $display("FAIL fetch_state op=%b step=%0d state_dbg=%0d want_fetch=%0d",
                 op, i, state_dbg, ph[i] == P_FETCH);
      end
      checks++;
      if (retired !== model_ret || s_retired !== model_ret[2:0]) begin
        errors++;
        $display("FAIL retired op=%b step=%0d got=%0d/%0d want=%0d/%0d",
                 op, i, retired, s_retired, model_ret, model_ret[2:0]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (retires) model_ret = model_ret + 32'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_ret = 32'd0;
  endtask

  task automatic test_reset();
    opCode = 6'b101011;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ctrl !== 18'd0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0", ctrl);
    end
    checks++;
    if (state_dbg !== 4'd0 || retired !== 32'd0 || s_retired !== 3'd0) begin
      errors++;
      $display("FAIL reset_state state_dbg=%0d retired=%0d small=%0d want 0/0/0",
               state_dbg, retired, s_retired);
    end
    reset = 1'b0;
    #1;
    model_ret = 32'd0;
  endtask

  task automatic test_rtype();
    run_instr(6'b000000);
    checks++;
    if (retired !== 32'd1) begin
      errors++; $display("FAIL rtype_retire got=%0d want=1", retired);
    end
  endtask

  task automatic test_lw();
    run_instr(6'b100011);
    checks++;
    if (state_dbg !== 4'd0) begin
      errors++; $display("FAIL lw_cpi state_dbg=%0d want=0 after 6 cycles", state_dbg);
    end
  endtask

  task automatic test_sw_beq();
    do_reset();
    run_instr(6'b101011);
    run_instr(6'b000100);
    checks++;
    if (retired !== 32'd2) begin
      errors++; $display("FAIL sw_beq_retire got=%0d want=2", retired);
    end
  endtask

  task automatic test_jump();
    run_instr(6'b000010);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) run_instr(rand_legal());
  endtask

  task automatic test_trap_hold(input logic [5:0] op, input int trap_ph);
    logic [3:0] held;
    run_instr(op);
    held = state_dbg;
    checks++;
    if (held === 4'd0) begin
      errors++; $display("FAIL trap_enter op=%b state_dbg=%0d want nonzero", op, held);
    end
    for (int c = 0; c < 100; c++) begin
      opCode = 6'($urandom);
      checks++;
      if (ctrl !== phase_ctrl(trap_ph) || state_dbg !== held || retired !== model_ret) begin
        errors++;
        $display("FAIL trap_hold op=%b cycle=%0d ctrl=%b want=%b state=%0d want=%0d",
                 op, c, ctrl, phase_ctrl(trap_ph), state_dbg, held);
      end
      @(posedge clk);
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    do begin
      op = 6'($urandom);
    end while (op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000,
                          6'b100011, 6'b101011, 6'b111111});
    test_trap_hold(6'b010101, P_TRAP);
    test_trap_hold(op, P_TRAP);
  endtask

  task automatic test_reset_mid_write();
    run_instr(6'b000010);
    opCode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (MemWrite !== 1'b1 || retired !== model_ret) begin
      errors++;
      $display("FAIL mid_write_pre MemWrite=%b retired=%0d want 1/%0d", MemWrite, retired, model_ret);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || ctrl !== 18'd0) begin
      errors++; $display("FAIL mid_write_drop MemWrite=%b ctrl=%b want 0", MemWrite, ctrl);
    end
    checks++;
    if (state_dbg !== 4'd0 || retired !== 32'd0 || s_retired !== 3'd0) begin
      errors++;
      $display("FAIL mid_write_reset state_dbg=%0d retired=%0d want 0/0", state_dbg, retired);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_ret = 32'd0;
    run_instr(6'b000000);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 8; k++) run_instr(rand_legal());
    checks++;
    if (s_retired !== 3'd0 || retired !== 32'd8) begin
      errors++;
      $display("FAIL wrap small=%0d full=%0d want 0/8", s_retired, retired);
    end
    run_instr(6'b001000);
    checks++;
    if (s_retired !== 3'd1) begin
      errors++; $display("FAIL wrap_next small=%0d want=1", s_retired);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw_beq();
    test_jump();
    test_back_to_back();
    test_trap_hold(6'b111111, P_HALT);
    test_illegal();
    test_reset_mid_write();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore finite-state controller that sequences the multicycle datapath: fetch, decode, execute, memory and write-back. It consumes the opcode from the instruction register and drives every datapath enable and select. It also traps halt and illegal opcodes and counts retired instructions. It is instantiated next to the datapath at top level, with its outputs wired one-to-one to the datapath control inputs.

## Interface
- RETIRE_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opCode  in  6  opcode field of instruction register
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALU register, 10 jump target
- ALUSrcB  out  2  00 B, 01 constant 1, 10 sign-extended imm, 11 imm<<2
- ALUOp  out  2  00 add, 01 subtract, 10 decode funct; datapath ALUOp port widens to 2 bits in the same change
- halted  out  1  sticky, HALT executed
- illegal_op  out  1  sticky, unknown opcode decoded
- retired  out  RETIRE_W  instructions completed
- state_dbg  out  4  current state encoding

## Operation
- Opcodes: RTYPE 000000, J 000010, BEQ 000100, ADDI 001000, LW 100011, SW 101011, HALT 111111; all others are illegal.
- Outputs are a pure function of state. Every control not listed for a state is 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1. Next state is IR_LOAD.
- IR_LOAD: IRWrite=1, which captures the RAM q, valid in this cycle. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, precomputing the branch target into the ALU register. Branches on opCode.
  - LW or SW goes to MEM_ADDR.
  - RTYPE goes to R_EXEC.
  - ADDI goes to I_EXEC.
  - BEQ goes to BRANCH.
  - J goes to JUMP.
  - HALT goes to HALT.
  - Any other opcode goes to TRAP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: IorD=1, MemRead=1, with the ALU inputs held as in MEM_ADDR. Next state is LW_WB.
- LW_WB: RegDst=0, MemtoReg=1, RegWrite=1. Next state is FETCH.
- MEM_WR: IorD=1, MemWrite=1, with the ALU inputs held. Next state is FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1. Next state is FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state is FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state is FETCH.
- HALT: halted=1, and the state is held until reset.
- TRAP: illegal_op=1, and the state is held until reset.
- retired increments by 1 on every transition into FETCH from LW_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP. It wraps from all-ones to 0. HALT and TRAP do not count.

## Timing
- Reset asserted: the state is forced to FETCH and retired is forced to 0.
  - All control outputs, halted and illegal_op are forced to 0 while reset is high, including FETCH's enables.
  - state_dbg shows the FETCH encoding during reset.
- First rising edge after deassertion: that cycle is FETCH.
- Reset asserted mid-instruction: enables drop asynchronously, no partial write occurs after assertion, and the instruction does not retire.
- The RAM has a one-cycle synchronous read. The address is captured on the edge ending FETCH or MEM_RD, and q is consumed in the following state.
- Cycles per instruction, from FETCH to the next FETCH: BEQ 4, J 4, RTYPE 5, ADDI 5, SW 5, LW 6.
- opCode is sampled only in DECODE. It is stable there because IRWrite is 0 outside IR_LOAD.

## Structure
- Package ctrl_pkg holds:
  - the state enum, 4-bit encoding, FETCH=0;
  - the opcode constants;
  - the ALUOp and ALUSrcB encodings.
- One sub-module, ctrl_out_decode: a combinational map from state to the control outputs. The top holds the state register, the next-state logic and the retired counter.

## Test plan
- Reset, then opCode=000000 at DECODE: the state sequence is FETCH, IR_LOAD, DECODE, R_EXEC, R_WB, FETCH. RegDst=1 and RegWrite=1 only in R_WB, and retired goes 0→1.
- LW (100011): 6 cycles. MemRead=1 in FETCH and MEM_RD, IorD=1 only in MEM_RD, MemtoReg=1 with RegWrite=1 in LW_WB.
- SW then BEQ: MemWrite=1 for exactly one cycle. BRANCH shows PCWriteCond=1, ALUOp=01, PCSource=01. retired=2 after both.
- J (000010): PCWrite=1 in exactly FETCH and JUMP, with PCSource=10 in JUMP.
- opCode=111111 gives halted=1, and the state is held for 100 cycles with all enables 0. opCode=010101 gives illegal_op=1, likewise held.
- Reset pulse during MEM_WR: MemWrite falls within the same cycle, the state returns to FETCH and retired reads 0. Separately, retired preloaded at 2^32−1 wraps to 0 on the next retire.
